// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg
//   Shared constants and types for the async_fifo read-side drain engine
//   (fifo_rd_stream) and its skid buffer (fifo_skid_buf).
//   Contents:
//     DATA_W_DEF    - default FIFO / stream word width
//     BUF_DEPTH_DEF - default skid-buffer depth (2 sustains one word per cycle)
//     STATS_W       - width of the optional pop counter
//     word_t        - stream word at the default width
package fifo_rd_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int BUF_DEPTH_DEF = 2;
  localparam int STATS_W       = 32;

  typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf
//   Small circular buffer that absorbs words arriving from the FIFO read port
//   and holds them until the downstream stream accepts them.
//   Ports:
//     clk, rst - clock, asynchronous active-high reset
//     push     - write din at the write pointer
//     pop      - advance the read pointer (head consumed downstream)
//     flush    - empty the buffer; takes priority over push/pop
//     din      - word to store
//     dout     - head word (entry at the read pointer)
//     valid    - buffer holds at least one word
//     count    - number of stored words, 0..DEPTH
module fifo_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = BUF_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W-1:0]            dout,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Explicit wrap so non-power-of-two depths still cycle through DEPTH entries.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign dout  = mem[rd_ptr];
  assign valid = (count != '0);

  // Storage is reset as well so the head reads as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side drain engine for async_fifo (rd_clk domain). Pops words from the
//   FIFO read port and presents them as a valid/ready stream. The FIFO's
//   one-cycle read latency is absorbed by a skid buffer, so back-pressure can
//   never cause a pop on empty or a lost word; one word per cycle is sustained.
//   Ports:
//     rd_clk, rd_rst - clock, asynchronous active-high reset
//     empty          - FIFO empty flag
//     rd_en          - FIFO pop strobe
//     rd_data        - FIFO read data, valid the cycle after rd_en is sampled
//     flush          - drop buffered and in-flight words
//     out_valid/out_ready/out_data - downstream stream
//     busy           - buffer non-empty or a pop still in flight
//   Optional build macro FIFO_RD_STATS_EN adds:
//     pop_cnt        - wrapping count of rd_en cycles
//     err_underrun   - sticky flag, rd_en seen while empty
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic               rd_clk,
  input  logic               rd_rst,
  input  logic               empty,
  output logic               rd_en,
  input  logic [DATA_W-1:0]  rd_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STATS_W-1:0] pop_cnt,
  output logic               err_underrun
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [CW-1:0] count;
  logic [CW:0]   committed;
  logic          inflight;
  logic          flush_drop;
  logic          pop;
  logic          push;

  assign pop  = out_valid & out_ready;
  assign push = inflight & ~flush_drop;

  // Slots already spoken for after this cycle: stored words plus the word in
  // flight, minus the head leaving now. Using this cycle's pop keeps the pipe
  // full at one word per cycle, at the cost of a combinational path from
  // out_ready to rd_en. Never underflows: pop implies count >= 1.
  assign committed = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign rd_en     = ~rd_rst & ~empty & ~flush & (committed < (CW+1)'(BUF_DEPTH));

  assign busy = out_valid | inflight;

  // inflight marks that rd_data carries a fresh word this cycle; flush_drop
  // masks a capture in the cycle after a flush.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      inflight   <= 1'b0;
      flush_drop <= 1'b0;
    end else begin
      inflight   <= rd_en;
      flush_drop <= flush;
    end
  end

  fifo_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk   (rd_clk),
    .rst   (rd_rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (rd_data),
    .dout  (out_data),
    .valid (out_valid),
    .count (count)
  );

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      pop_cnt      <= '0;
      err_underrun <= 1'b0;
    end else begin
      if (rd_en)         pop_cnt      <= pop_cnt + STATS_W'(1);
      if (rd_en & empty) err_underrun <= 1'b1;
    end
  end
`endif

endmodule
